seq_comparator: RTL and testbench
=================================

SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 4, bits compared per clock.
REQ-003 Derived constant NCHUNK = WIDTH/CHUNK, the number of compare cycles.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request a compare; honoured only in IDLE.
REQ-007 a  input  WIDTH  operand A; sampled on an accepted start.
REQ-008 b  input  WIDTH  operand B; sampled on an accepted start.
REQ-009 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled on an accepted start.
REQ-010 lt_in, eq_in, gt_in  input  1 each  cascade inputs from a less-significant stage; sampled on an accepted start.
REQ-011 busy  output  1  high while a compare is in progress.
REQ-012 done  output  1  one-cycle pulse when the result becomes valid.
REQ-013 lt_out, eq_out, gt_out  output  1 each  result flags, held until the next done.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 Transitions: IDLE->RUN on start; RUN->DONE after the last chunk; DONE->IDLE unconditionally.
REQ-016 On accepted start: latch a, b, signed_mode and the cascade inputs; clear the chunk index to 0.
REQ-017 RUN SHALL compare one CHUNK slice per cycle, MSB-first; slice k covers bits [WIDTH-1-k*CHUNK -: CHUNK].
REQ-018 The first unequal slice SHALL decide the result; all later slices SHALL NOT change it.
REQ-019 Signed mode: the operand MSBs are inverted before the slice-0 compare.
REQ-020 Signed mode has no effect on the other slices.
REQ-021 If all slices are equal, the result SHALL come from the cascade inputs with priority eq_in > gt_in > lt_in.
REQ-022 If all slices are equal and no cascade input is high, the result SHALL be EQ.
REQ-023 Without early exit, start-to-done latency is NCHUNK+1 clocks: start is sampled at edge 0 and done is high after edge NCHUNK+1.
REQ-024 busy SHALL be high in RUN only; done SHALL be high in DONE only.
REQ-025 The result flags SHALL update on the edge entering DONE, with exactly one flag high.
REQ-026 start asserted in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-027 start is accepted again in the IDLE cycle immediately after DONE.
REQ-028 a, b and the cascade inputs changing during RUN SHALL NOT affect the result.
REQ-029 NCHUNK=1 is legal: one RUN cycle.

Reset
REQ-030 When rst_n=0 at a rising edge: state=IDLE, busy=0, done=0, lt_out=0, eq_out=0, gt_out=0, chunk index=0, latched operands cleared.
REQ-031 Reset mid-RUN SHALL abort the compare with no done pulse.
REQ-032 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-033 Macro SEQ_CMP_EARLY_EXIT_EN, when defined: RUN SHALL go to DONE on the edge after the first unequal slice, so latency = k+2 clocks for deciding slice k.
REQ-034 Without SEQ_CMP_EARLY_EXIT_EN: latency is always NCHUNK+1 clocks, independent of the data.

Structure
REQ-035 Package seq_cmp_pkg SHALL hold the FSM state enum, the 3-bit result encoding (LT/EQ/GT) and the parameter-legality check WIDTH % CHUNK == 0.
REQ-036 Sub-module cmp_slice SHALL be a combinational CHUNK-bit comparator with cascade in/out, instantiated once and reused each RUN cycle.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-037 a=16'h1234, b=16'h1234, unsigned, eq_in=1 -> eq_out=1; done exactly 5 clocks after start.
REQ-038 a=16'h8000, b=16'h7FFF: unsigned -> gt_out=1; signed -> lt_out=1.
REQ-039 a=16'h4000, b=16'hC000 with SEQ_CMP_EARLY_EXIT_EN defined -> gt_out=1, done 2 clocks after start; macro undefined -> done 5 clocks after start.
REQ-040 Equal operands with gt_in=1, eq_in=0 -> gt_out=1; no cascade input high -> eq_out=1.
REQ-041 start re-pulsed during RUN with different a/b -> first result unchanged, one done only; start in the IDLE cycle after done -> accepted.
REQ-042 rst_n=0 during the third RUN cycle -> no done, all outputs 0, next start completes normally.

Source files
------------

// File: rtl/seq_cmp_pkg.sv
// -----------------------------------------------------------------------------
// seq_cmp_pkg
// Shared types and helpers for the sequential magnitude comparator:
//   state_t          - controller FSM states (IDLE / RUN / DONE)
//   result_t         - one-hot result encoding {lt, eq, gt}
//   chunk_cfg_ok     - parameter legality check (WIDTH must be a multiple of CHUNK)
//   resolve_cascade  - folds the cascade inputs into a fully-equal result
// -----------------------------------------------------------------------------
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit order matches the output flags {lt_out, eq_out, gt_out}.
  typedef enum logic [2:0] {
    RES_LT = 3'b100,
    RES_EQ = 3'b010,
    RES_GT = 3'b001
  } result_t;

  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

  // A decided (unequal) result always wins. Only when every slice matched do
  // the less-significant stage's flags matter, with priority eq > gt > lt and
  // EQ as the answer when none of them is set.
  function automatic result_t resolve_cascade(input result_t r,
                                              input logic    lt_in,
                                              input logic    eq_in,
                                              input logic    gt_in);
    if (r != RES_EQ) return r;
    if (eq_in)       return RES_EQ;
    if (gt_in)       return RES_GT;
    if (lt_in)       return RES_LT;
    return RES_EQ;
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// -----------------------------------------------------------------------------
// cmp_slice
// Combinational CHUNK-bit magnitude comparator with cascade in/out. The cascade
// input carries the result of the more-significant slices already examined;
// once that result is unequal it passes straight through, so only the first
// differing slice ever decides.
// Ports:
//   a, b        CHUNK-bit slices of the two operands
//   invert_msb  flip both slice MSBs (turns a signed compare into unsigned)
//   cas_in      result so far from more-significant slices
//   cas_out     result including this slice
// -----------------------------------------------------------------------------
module cmp_slice
  import seq_cmp_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             invert_msb,
  input  result_t          cas_in,
  output result_t          cas_out
);

  logic [CHUNK-1:0] a_x;
  logic [CHUNK-1:0] b_x;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    a_x     = a;
    b_x     = b;
    cas_out = cas_in;
    // Flipping the sign bit of both operands maps two's-complement ordering
    // onto unsigned ordering.
    if (invert_msb) begin
      a_x[CHUNK-1] = ~a[CHUNK-1];
      b_x[CHUNK-1] = ~b[CHUNK-1];
    end
    if (cas_in == RES_EQ) begin
      if (a_x > b_x)      cas_out = RES_GT;
      else if (a_x < b_x) cas_out = RES_LT;
    end
  end

endmodule

// File: rtl/seq_comparator.sv
// -----------------------------------------------------------------------------
// seq_comparator
// Sequential WIDTH-bit magnitude comparator that examines CHUNK bits per clock,
// most-significant slice first, reusing a single cmp_slice instance.
//
// Ports:
//   clk                     rising-edge clock
//   rst_n                   synchronous active-low reset
//   start                   request a compare (accepted only in IDLE)
//   a, b                    operands, latched on an accepted start
//   signed_mode             1 = two's-complement, 0 = unsigned (latched)
//   lt_in, eq_in, gt_in     cascade from a less-significant stage (latched)
//   busy                    high while in RUN
//   done                    one-cycle pulse in DONE
//   lt_out, eq_out, gt_out  result flags, held until the next done
//
// Configuration macro:
//   SEQ_CMP_EARLY_EXIT_EN   when defined, RUN ends on the cycle after the first
//                           unequal slice instead of always scanning every slice.
//
// Timing: slice k is compared during RUN cycle k and registered on the
// following edge; DONE is entered one edge after the deciding result is
// registered (or after the last slice), giving NCHUNK+1 clocks start-to-done,
// or k+2 clocks with early exit when slice k decides.
// -----------------------------------------------------------------------------
module seq_comparator
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             lt_in,
  input  logic             eq_in,
  input  logic             gt_in,
  output logic             busy,
  output logic             done,
  output logic             lt_out,
  output logic             eq_out,
  output logic             gt_out
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = $clog2(NCHUNK + 1);

  generate
    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("seq_comparator: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic             cas_lt_q;
  logic             cas_eq_q;
  logic             cas_gt_q;
  logic [IDX_W-1:0] idx_q;
  result_t          res_q;
  logic [2:0]       flags_q;

  logic             invert_msb;
  result_t          slice_res;
  logic             last_slice_done;
  logic             finish;

  // The operand registers shift left each RUN cycle, so the slice under test is
  // always the top CHUNK bits and no variable part-select is needed.
  assign invert_msb      = signed_q && (idx_q == '0);
  assign last_slice_done = (idx_q == IDX_W'(NCHUNK));

`ifdef SEQ_CMP_EARLY_EXIT_EN
  assign finish = last_slice_done || (res_q != RES_EQ);
`else
  assign finish = last_slice_done;
`endif

  cmp_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a          (a_q[WIDTH-1 -: CHUNK]),
    .b          (b_q[WIDTH-1 -: CHUNK]),
    .invert_msb (invert_msb),
    .cas_in     (res_q),
    .cas_out    (slice_res)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the operand registers are reset too, not just the control state,
      // so nothing stale from an aborted compare survives a reset.
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      cas_lt_q <= 1'b0;
      cas_eq_q <= 1'b0;
      cas_gt_q <= 1'b0;
      idx_q    <= '0;
      res_q    <= RES_EQ;
      flags_q  <= 3'b000;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_mode;
            cas_lt_q <= lt_in;
            cas_eq_q <= eq_in;
            cas_gt_q <= gt_in;
            idx_q    <= '0;
            res_q    <= RES_EQ;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (finish) begin
            flags_q <= resolve_cascade(res_q, cas_lt_q, cas_eq_q, cas_gt_q);
            state_q <= S_DONE;
          end else begin
            res_q <= slice_res;
            a_q   <= a_q << CHUNK;
            b_q   <= b_q << CHUNK;
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy                     = (state_q == S_RUN);
  assign done                     = (state_q == S_DONE);
  assign {lt_out, eq_out, gt_out} = flags_q;

endmodule

// File: tb/tb_seq_comparator.sv
// -----------------------------------------------------------------------------
// tb_seq_comparator
// Directed self-checking bench for seq_comparator (WIDTH=16, CHUNK=4).
// Expected flags use the {lt, eq, gt} order; expected latencies follow the
// early-exit macro when it is defined.
// -----------------------------------------------------------------------------
module tb_seq_comparator;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

`ifdef SEQ_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [2:0] F_LT = 3'b100;
  localparam logic [2:0] F_EQ = 3'b010;
  localparam logic [2:0] F_GT = 3'b001;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             lt_in;
  logic             eq_in;
  logic             gt_in;
  logic             busy;
  logic             done;
  logic             lt_out;
  logic             eq_out;
  logic             gt_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [15:0] va;
    logic [15:0] vb;
    logic        sm;
    logic        lt;
    logic        eq;
    logic        gt;
    logic [2:0]  exp;
    int          k;     // deciding slice, -1 when all slices are equal
  } vec_t;

  seq_comparator #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .lt_in       (lt_in),
    .eq_in       (eq_in),
    .gt_in       (gt_in),
    .busy        (busy),
    .done        (done),
    .lt_out      (lt_out),
    .eq_out      (eq_out),
    .gt_out      (gt_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_lat(input int k);
    if (EARLY && (k >= 0)) return k + 2;
    return NCHUNK + 1;
  endfunction

  // Drives one start (inputs applied now, sampled at the next edge) and watches
  // a fixed window of edges. lat is the number of edges after the start edge
  // until done is first seen (-1 if never); ndone counts done cycles.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic sm, input logic tlt, input logic teq,
                        input logic tgt, output int lat, output logic [2:0] flags,
                        output int ndone, output logic busy0);
    a = ta; b = tb_v; signed_mode = sm;
    lt_in = tlt; eq_in = teq; gt_in = tgt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy0 = busy;
    lat   = -1;
    flags = 3'b000;
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat   = i;
          flags = {lt_out, eq_out, gt_out};
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    a = 16'h0001; b = 16'h0002;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done got %b required 00", {busy, done});
    end
    checks++;
    if ({lt_out, eq_out, gt_out} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000", {lt_out, eq_out, gt_out});
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_queue: busy got %b required 0", busy);
    end
  endtask

  task automatic test_cascade;
    vec_t tbl [6];
    int lat, ndone;
    logic [2:0] flags;
    logic busy0;
    tbl[0] = '{"eq_1234",   16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, F_EQ, -1};
    tbl[1] = '{"cas_gt",    16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b1, F_GT, -1};
    tbl[2] = '{"cas_none",  16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, F_EQ, -1};
    tbl[3] = '{"cas_lt",    16'hABCD, 16'hABCD, 1'b1, 1'b1, 1'b0, 1'b0, F_LT, -1};
    tbl[4] = '{"cas_all",   16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b1, 1'b1, F_EQ, -1};
    tbl[5] = '{"cas_gt_lt", 16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0, 1'b1, F_GT, -1};
    foreach (tbl[i]) begin
      run_op(tbl[i].va, tbl[i].vb, tbl[i].sm, tbl[i].lt, tbl[i].eq, tbl[i].gt,
             lat, flags, ndone, busy0);
      checks++;
      if (flags !== tbl[i].exp) begin
        errors++;
        $display("FAIL %s flags: got %b required %b", tbl[i].name, flags, tbl[i].exp);
      end
      checks++;
      if (lat !== exp_lat(tbl[i].k)) begin
        errors++;
        $display("FAIL %s latency: got %0d required %0d", tbl[i].name, lat, exp_lat(tbl[i].k));
      end
      checks++;
      if (ndone !== 1 || busy0 !== 1'b1) begin
        errors++;
        $display("FAIL %s handshake: done_count %0d busy %b required 1 1", tbl[i].name, ndone, busy0);
      end
    end
  endtask

  task automatic test_signed;
    vec_t tbl [5];
    int lat, ndone;
    logic [2:0] flags;
    logic busy0;
    tbl[0] = '{"u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, F_GT, 0};
    tbl[1] = '{"s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, F_LT, 0};
    tbl[2] = '{"s_4000_c000", 16'h4000, 16'hC000, 1'b1, 1'b0, 1'b0, 1'b0, F_GT, 0};
    tbl[3] = '{"u_4000_c000", 16'h4000, 16'hC000, 1'b0, 1'b0, 1'b0, 1'b0, F_LT, 0};
    tbl[4] = '{"s_fff8_fff9", 16'hFFF8, 16'hFFF9, 1'b1, 1'b0, 1'b0, 1'b0, F_LT, 3};
    foreach (tbl[i]) begin
      run_op(tbl[i].va, tbl[i].vb, tbl[i].sm, tbl[i].lt, tbl[i].eq, tbl[i].gt,
             lat, flags, ndone, busy0);
      checks++;
      if (flags !== tbl[i].exp) begin
        errors++;
        $display("FAIL %s flags: got %b required %b", tbl[i].name, flags, tbl[i].exp);
      end
      checks++;
      if (lat !== exp_lat(tbl[i].k)) begin
        errors++;
        $display("FAIL %s latency: got %0d required %0d", tbl[i].name, lat, exp_lat(tbl[i].k));
      end
      checks++;
      if (ndone !== 1) begin
        errors++;
        $display("FAIL %s done_count: got %0d required 1", tbl[i].name, ndone);
      end
    end
  endtask

  task automatic test_slice_order;
    vec_t tbl [5];
    int lat, ndone;
    logic [2:0] flags;
    logic busy0;
    tbl[0] = '{"first_wins",  16'h1000, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0, F_GT, 0};
    tbl[1] = '{"slice1",      16'h0A00, 16'h0B00, 1'b0, 1'b0, 1'b0, 1'b1, F_LT, 1};
    tbl[2] = '{"slice2",      16'h12F4, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, F_GT, 2};
    tbl[3] = '{"slice3_casc", 16'h1235, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, F_GT, 3};
    tbl[4] = '{"s_low_slice", 16'h7123, 16'h7124, 1'b1, 1'b0, 1'b0, 1'b0, F_LT, 3};
    foreach (tbl[i]) begin
      run_op(tbl[i].va, tbl[i].vb, tbl[i].sm, tbl[i].lt, tbl[i].eq, tbl[i].gt,
             lat, flags, ndone, busy0);
      checks++;
      if (flags !== tbl[i].exp) begin
        errors++;
        $display("FAIL %s flags: got %b required %b", tbl[i].name, flags, tbl[i].exp);
      end
      checks++;
      if (lat !== exp_lat(tbl[i].k)) begin
        errors++;
        $display("FAIL %s latency: got %0d required %0d", tbl[i].name, lat, exp_lat(tbl[i].k));
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, ndone, waited;
    logic [2:0] flags;
    logic busy0;
    // 0x0001 < 0x0002, decided on the last slice; a re-start with a GT pair
    // and changed cascade inputs arrives mid-RUN and must be ignored.
    a = 16'h0001; b = 16'h0002; signed_mode = 1'b0;
    lt_in = 1'b0; eq_in = 1'b0; gt_in = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; ndone = 0; flags = 3'b000;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin
        start = 1'b1; a = 16'hFFFF; b = 16'h0000; gt_in = 1'b1; eq_in = 1'b1;
      end else if (i == 4) begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat   = i;
          flags = {lt_out, eq_out, gt_out};
        end
      end
    end
    checks++;
    if (flags !== F_LT) begin
      errors++;
      $display("FAIL restart_ignored flags: got %b required %b", flags, F_LT);
    end
    checks++;
    if (ndone !== 1 || lat !== NCHUNK + 1) begin
      errors++;
      $display("FAIL restart_ignored done: count %0d latency %0d required 1 %0d", ndone, lat, NCHUNK + 1);
    end

    // Start held high from the DONE cycle: ignored in DONE, accepted in the
    // following IDLE cycle.
    a = 16'h0005; b = 16'h0003; gt_in = 1'b0; eq_in = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (!done && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_wait: done got %b required 1 within 20 cycles", done);
    end
    a = 16'h0003; b = 16'h0005;
    start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: busy/done got %b%b required 00", busy, done);
    end
    // start is still high: this edge is the IDLE cycle right after DONE.
    run_op(16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, lat, flags, ndone, busy0);
    checks++;
    if (busy0 !== 1'b1 || flags !== F_LT || lat !== NCHUNK + 1) begin
      errors++;
      $display("FAIL idle_accept: busy %b flags %b latency %0d required 1 %b %0d",
               busy0, flags, lat, F_LT, NCHUNK + 1);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, ndone;
    logic [2:0] flags;
    logic busy0;
    // Equal operands never exit early, so RUN is long enough in both builds.
    a = 16'h5A5A; b = 16'h5A5A; signed_mode = 1'b0;
    lt_in = 1'b0; eq_in = 1'b1; gt_in = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_busy: got %b required 1", busy);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, lt_out, eq_out, gt_out} !== 5'b00000) begin
      errors++;
      $display("FAIL mid_run_reset outputs: got %b required 00000",
               {busy, done, lt_out, eq_out, gt_out});
    end
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL mid_run_abort: done_count got %0d required 0", ndone);
    end
    run_op(16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, lat, flags, ndone, busy0);
    checks++;
    if (flags !== F_GT || lat !== exp_lat(3) || ndone !== 1) begin
      errors++;
      $display("FAIL after_reset_op: flags %b latency %0d count %0d required %b %0d 1",
               flags, lat, ndone, F_GT, exp_lat(3));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    lt_in = 1'b0; eq_in = 1'b0; gt_in = 1'b0;
    test_reset();
    test_cascade();
    test_signed();
    test_slice_order();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
